seq_div4: RTL and testbench



---
 rtl/seq_div_pkg.sv | 20 ++
 rtl/seq_div4_if.sv | 33 +++
 rtl/seq_div4_div_step.sv | 21 ++
 rtl/seq_div4.sv | 129 ++++++++++++
 tb/tb_seq_div4.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package seq_div_pkg;

    // Default divisor/remainder width; dividend and quotient are twice this.
    localparam int W_DEF = 4;

    // Iteration counter width needed to count 0..2W-1.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(2 * w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_w(W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div4_if.sv
// Bus bundle for seq_div4: operands, results and the start/busy/done handshake.
//
// Handshake: start is sampled only on enabled clock edges while the divider
// is not busy (IDLE or DONE); that edge captures a and b. busy is high for the
// whole iteration phase, then done pulses for one enabled cycle with q/r valid.
// busy and done are never high together. start while busy is ignored.
// q, r and dz hold their values until the next result is written.
interface seq_div4_if
    import seq_div_pkg::*;
#(
    parameter int W = W_DEF
);
    logic           en;
    logic           start;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           busy;
    logic           done;
    logic           dz;
    state_t         state;   // FSM state, exported for debug/checkers

    modport master (
        output en, start, a, b,
        input  q, r, busy, done, dz, state
    );

    modport slave (
        input  en, start, a, b,
        output q, r, busy, done, dz, state
    );
endinterface

// File: rtl/seq_div4_div_step.sv
// One restoring-division iteration: compare the shifted partial remainder
// against the divisor and subtract when it fits.
module div_step
    import seq_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W:0]   rem_p,     // {rem, next dividend bit}
    input  logic [W-1:0] b,
    output logic [W-1:0] rem_next,
    output logic         qbit
);

    // Compare/subtract; the result always fits W bits because rem_p < 2*b
    // whenever the subtraction is taken (and b=0 keeps only the low W bits).
    always_comb begin
        qbit     = (rem_p >= {1'b0, b});
        rem_next = qbit ? W'(rem_p - {1'b0, b}) : rem_p[W-1:0];
    end

endmodule

// File: rtl/seq_div4.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one
// iteration per enabled clock, 2W iterations per division.
// Optional feature macro: SEQ_DIV_DZ_CHECK_EN -- short-circuits b=0 to a
// one-cycle result with the dz flag set; without it dz is tied low and b=0
// runs the full iteration count.
module seq_div4
    import seq_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic       clk,
    input  logic       clr,
    seq_div4_if.slave  bus
);

    localparam int             CW   = (W == W_DEF) ? CNT_W_DEF : cnt_w(W);
    localparam logic [CW-1:0]  LAST = CW'(2 * W - 1);

    state_t         state;
    logic [CW-1:0]  count;
    logic [2*W-1:0] dvd;       // dividend, shifted left one bit per iteration
    logic [W-1:0]   dvs;       // captured divisor
    logic [W-1:0]   rem;       // partial remainder
    logic [2*W-1:0] quo;       // quotient being assembled
    logic [2*W-1:0] q_r;
    logic [W-1:0]   r_r;
    logic           busy_r;
    logic           done_r;

    logic [W:0]     rem_p;
    logic [W-1:0]   rem_next;
    logic           qbit;

    assign rem_p = {rem, dvd[2*W-1]};

    div_step #(.W(W)) u_step (
        .rem_p    (rem_p),
        .b        (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

`ifdef SEQ_DIV_DZ_CHECK_EN
    logic dz_r;

    // Divide-by-zero flag: set by a b=0 start, cleared by any other start.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dz_r <= 1'b0;
        end else if (bus.en && bus.start && (state != RUN)) begin
            dz_r <= (bus.b == '0);
        end
    end

    assign bus.dz = dz_r;
`else
    assign bus.dz = 1'b0;
`endif

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            count  <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            q_r    <= '0;
            r_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.en) begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        dvd   <= bus.a;
                        dvs   <= bus.b;
                        rem   <= '0;
                        quo   <= '0;
                        count <= '0;
`ifdef SEQ_DIV_DZ_CHECK_EN
                        if (bus.b == '0) begin
                            // Skip the iterations; the answer is known.
                            q_r    <= '1;
                            r_r    <= bus.a[W-1:0];
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= DONE;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= RUN;
                        end
`else
                        busy_r <= 1'b1;
                        state  <= RUN;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    dvd   <= {dvd[2*W-2:0], 1'b0};
                    rem   <= rem_next;
                    quo   <= {quo[2*W-2:0], qbit};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        q_r    <= {quo[2*W-2:0], qbit};
                        r_r    <= rem_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.q     = q_r;
    assign bus.r     = r_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.state = state;

endmodule

// File: tb/tb_seq_div4.sv
// Self-checking bench for seq_div4: directed scenarios with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_seq_div4;
    import seq_div_pkg::*;

    localparam int W   = W_DEF;
    localparam int LAT = 2 * W;

    logic clk = 1'b0;
    logic clr = 1'b1;

    seq_div4_if #(.W(W)) bus ();

    seq_div4 #(.W(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- counters ----------------
    int vectors = 0;
    int errors  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Result of a division from plain arithmetic; b=0 gives all ones / low bits of a.
    function automatic logic [3*W-1:0] ref_div(input logic [2*W-1:0] av, input logic [W-1:0] bv);
        logic [2*W-1:0] qq;
        logic [2*W-1:0] rr;
        if (bv == '0) begin
            qq = '1;
            rr = {{W{1'b0}}, av[W-1:0]};
        end else begin
            qq = av / {{W{1'b0}}, bv};
            rr = av % {{W{1'b0}}, bv};
        end
        return {qq, rr[W-1:0]};
    endfunction

    logic [3*W-1:0] exp_q[$];          // results of accepted, not-yet-finished divisions
    logic [3*W-1:0] res;
    int             left  = 0;         // enabled cycles until the pending result appears
    logic [2*W-1:0] m_q   = '0;
    logic [W-1:0]   m_r   = '0;
    logic           m_done = 1'b0;
    logic           m_dz   = 1'b0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            left   = 0;
            m_q    = '0;
            m_r    = '0;
            m_done = 1'b0;
            m_dz   = 1'b0;
            exp_q.delete();
        end else if (bus.en) begin
            if (left != 0) begin
                left--;
                if (left == 0) begin
                    res    = exp_q.pop_front();
                    m_q    = res[3*W-1:W];
                    m_r    = res[W-1:0];
                    m_done = 1'b1;
                end
            end else begin
                m_done = 1'b0;
                if (bus.start) begin
                    exp_q.push_back(ref_div(bus.a, bus.b));
                    m_dz = 1'b0;
`ifdef SEQ_DIV_DZ_CHECK_EN
                    if (bus.b == '0) begin
                        res    = exp_q.pop_front();
                        m_q    = res[3*W-1:W];
                        m_r    = res[W-1:0];
                        m_done = 1'b1;
                        m_dz   = 1'b1;
                    end else begin
                        left = LAT;
                    end
`else
                    left = LAT;
`endif
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if ({bus.q, bus.r, bus.busy, bus.done, bus.dz} !==
                {m_q, m_r, (left != 0), m_done, m_dz}) begin
                errors++;
                $display("FAIL cycle t=%0t: q=%0d r=%0d busy=%b done=%b dz=%b, expected q=%0d r=%0d busy=%b done=%b dz=%b",
                         $time, bus.q, bus.r, bus.busy, bus.done, bus.dz,
                         m_q, m_r, (left != 0), m_done, m_dz);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge: pulse start for one cycle, optionally drop en for a
    // window, and count negedges until done (cyc) and busy negedges (bcyc).
    task automatic start_and_wait(input logic [2*W-1:0] av, input logic [W-1:0] bv,
                                  input int en_off_at, input int en_off_len,
                                  output int cyc, output int bcyc);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        cyc       = 0;
        bcyc      = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == en_off_at) bus.en = 1'b0;
            if (i == en_off_at + en_off_len) bus.en = 1'b1;
            if (bus.busy) bcyc++;
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        bus.en = 1'b1;
        if (cyc == 0) begin
            vectors++;
            errors++;
            $display("FAIL timeout: no done for a=%0d b=%0d", av, bv);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            vectors++;
            errors++;
            $display("FAIL timeout: no done observed");
        end
    endtask

    // ---------------- stimulus ----------------
    int cyc;
    int bcyc;
    bit done_seen;

    initial begin
        bus.en    = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset q",     bus.q,     0);
        check("reset r",     bus.r,     0);
        check("reset busy",  bus.busy,  0);
        check("reset done",  bus.done,  0);
        check("reset dz",    bus.dz,    0);
        check("reset state", bus.state, IDLE);
        @(posedge clk);
        #2 clr = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;

        // 100 / 7
        start_and_wait(8'd100, 4'd7, 0, 0, cyc, bcyc);
        check("basic latency", cyc,  LAT + 1);
        check("basic busy",    bcyc, LAT);
        check("basic q",       bus.q, 14);
        check("basic r",       bus.r, 2);

        // 100 / 7 with en low for 5 cycles mid-run
        start_and_wait(8'd100, 4'd7, 3, 5, cyc, bcyc);
        check("en-stall latency", cyc, LAT + 1 + 5);
        check("en-stall q",       bus.q, 14);
        check("en-stall r",       bus.r, 2);

        // Back-to-back with start held: 255/1 then 15/15
        bus.a = 8'd255; bus.b = 4'd1; bus.start = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.a = 8'd15;
                bus.b = 4'd15;
            end
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        check("b2b first latency", cyc, LAT + 1);
        check("b2b first q", bus.q, 255);
        check("b2b first r", bus.r, 0);
        @(negedge clk);
        check("b2b no idle", bus.busy, 1);
        bus.start = 1'b0;
        wait_done(cyc);
        check("b2b second latency", cyc, LAT);
        check("b2b second q", bus.q, 1);
        check("b2b second r", bus.r, 0);

        // 200 / 3 with an ignored start during RUN
        bus.a = 8'd200; bus.b = 4'd3; bus.start = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == 2) begin
                bus.start = 1'b1;
                bus.a = 8'd9;
                bus.b = 4'd2;
            end
            if (i == 3) bus.start = 1'b0;
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        check("ignore latency", cyc, LAT + 1);
        check("ignore q", bus.q, 66);
        check("ignore r", bus.r, 2);

        // 77 / 0
        start_and_wait(8'd77, 4'd0, 0, 0, cyc, bcyc);
`ifdef SEQ_DIV_DZ_CHECK_EN
        check("dz latency", cyc, 1);
        check("dz flag",    bus.dz, 1);
`else
        check("dz latency", cyc, LAT + 1);
        check("dz flag",    bus.dz, 0);
`endif
        check("dz q", bus.q, 255);
        check("dz r", bus.r, 13);

        // clr three cycles after start
        bus.a = 8'd100; bus.b = 4'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr q",    bus.q,    0);
        check("clr r",    bus.r,    0);
        check("clr busy", bus.busy, 0);
        check("clr done", bus.done, 0);
        check("clr dz",   bus.dz,   0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 clr = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        check("clr no stale done", done_seen, 0);
        start_and_wait(8'd100, 4'd7, 0, 0, cyc, bcyc);
        check("post-clr latency", cyc, LAT + 1);
        check("post-clr q", bus.q, 14);
        check("post-clr r", bus.r, 2);

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            bus.en    = ($urandom_range(0, 7) != 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = (2*W)'($urandom);
            bus.b     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk);
        bus.en    = 1'b1;
        bus.start = 1'b0;
        repeat (3 * LAT) @(negedge clk);
        check("drain idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
